// File: rtl/joypad_responder.sv
// NES controller-side responder: samples eight buttons on latch and shifts them
// out LSB-first on each host clock rising edge, 4021-style, with A/B auto-fire.
module joypad_responder #(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter bit          LATCH_ACTIVE_HIGH = 1'b1,
    parameter bit          DATA_ACTIVE_LOW   = 1'b1,
    parameter int unsigned TURBO_FRAMES      = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       jp_latch_in,
    input  logic       jp_clk_in,
    input  logic [7:0] buttons_in,
    input  logic       turbo_a_in,
    input  logic       turbo_b_in,
    output logic       jp_data_out,
    output logic [3:0] bit_cnt_out,
    output logic       frame_strobe_out
);

    localparam int unsigned SYNC_W  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned TURBO_N = (TURBO_FRAMES < 1) ? 1 : TURBO_FRAMES;
    localparam int unsigned TURBO_W = (TURBO_N > 1) ? $clog2(TURBO_N) : 1;
    localparam int unsigned BTN_W   = 8;
    localparam int unsigned CNT_W   = 4;

    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(BTN_W);
    localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_N - 1);
    localparam logic               LATCH_IDLE = ~LATCH_ACTIVE_HIGH;

    // The normalized latch level is the state; there is no separate state flop.
    typedef enum logic {
        ST_SHIFT = 1'b0,
        ST_LOAD  = 1'b1
    } state_e;

    logic [SYNC_W-1:0]  latch_sync;
    logic [SYNC_W-1:0]  clk_sync;
    logic               latch_q;
    logic               clk_q;
    logic [BTN_W-1:0]   shift_q;
    logic [TURBO_W-1:0] turbo_cnt_q;
    logic               turbo_phase_q;

    logic               latch_s;
    logic               clk_s;
    logic               clk_rise;
    logic               latch_fall;
    state_e             state;
    logic [BTN_W-1:0]   eff;

    logic [BTN_W-1:0]   shift_d;
    logic [CNT_W-1:0]   bit_cnt_d;
    logic [TURBO_W-1:0] turbo_cnt_d;
    logic               turbo_phase_d;
    logic               data_d;
    logic               strobe_d;

    assign latch_s    = LATCH_ACTIVE_HIGH ? latch_sync[SYNC_W-1] : ~latch_sync[SYNC_W-1];
    assign clk_s      = clk_sync[SYNC_W-1];
    assign clk_rise   = ~clk_q & clk_s;
    assign latch_fall = latch_q & ~latch_s;
    assign state      = latch_s ? ST_LOAD : ST_SHIFT;

    // Auto-fire masks A/B off during the released half of the turbo cycle.
    always_comb begin
        eff    = buttons_in;
        eff[0] = buttons_in[0] & (~turbo_a_in | turbo_phase_q);
        eff[1] = buttons_in[1] & (~turbo_b_in | turbo_phase_q);
    end

    // State register: synchronizers, edge history and shift datapath.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            latch_sync       <= {SYNC_W{LATCH_IDLE}};
            clk_sync         <= '1;
            latch_q          <= 1'b0;
            clk_q            <= 1'b1;
            shift_q          <= '0;
            bit_cnt_out      <= '0;
            turbo_cnt_q      <= '0;
            turbo_phase_q    <= 1'b0;
            jp_data_out      <= DATA_ACTIVE_LOW;
            frame_strobe_out <= 1'b0;
        end else begin
            latch_sync       <= {latch_sync[SYNC_W-2:0], jp_latch_in};
            clk_sync         <= {clk_sync[SYNC_W-2:0], jp_clk_in};
            latch_q          <= latch_s;
            clk_q            <= clk_s;
            shift_q          <= shift_d;
            bit_cnt_out      <= bit_cnt_d;
            turbo_cnt_q      <= turbo_cnt_d;
            turbo_phase_q    <= turbo_phase_d;
            jp_data_out      <= data_d;
            frame_strobe_out <= strobe_d;
        end
    end

    // Next state: load wins over any clock edge; shifting saturates the count at 8.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_out;
        unique case (state)
            ST_LOAD: begin
                shift_d   = eff;
                bit_cnt_d = '0;
            end
            ST_SHIFT: begin
                if (clk_rise) begin
                    shift_d   = {1'b1, shift_q[BTN_W-1:1]};
                    bit_cnt_d = (bit_cnt_out == CNT_MAX) ? CNT_MAX : bit_cnt_out + CNT_W'(1);
                end
            end
            default: begin
                shift_d   = shift_q;
                bit_cnt_d = bit_cnt_out;
            end
        endcase
    end

    // Turbo phase flips once every TURBO_N frames.
    always_comb begin
        turbo_cnt_d   = turbo_cnt_q;
        turbo_phase_d = turbo_phase_q;
        if (latch_fall) begin
            if (turbo_cnt_q == TURBO_LAST) begin
                turbo_cnt_d   = '0;
                turbo_phase_d = ~turbo_phase_q;
            end else begin
                turbo_cnt_d = turbo_cnt_q + TURBO_W'(1);
            end
        end
    end

    // Outputs: data tracks the next shift LSB so the pin updates with the register.
    always_comb begin
        data_d   = shift_d[0] ^ DATA_ACTIVE_LOW;
        strobe_d = latch_fall;
    end

endmodule

// File: tb/tb_joypad_responder.sv
// Bench for joypad_responder: default, TURBO_FRAMES=2 and inverted-polarity
// instances driven in lockstep and checked against a queued expectation model.
module tb_joypad_responder;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       jp_latch;
    logic       jp_latch_n;
    logic       jp_clk;
    logic [7:0] buttons;
    logic       turbo_a;
    logic       turbo_b;

    logic       data_m, data_t, data_p;
    logic [3:0] cnt_m, cnt_t, cnt_p;
    logic       strb_m, strb_t, strb_p;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int nstrb_m = 0, nstrb_t = 0, nstrb_p = 0;

    // Turbo model for TURBO_FRAMES = 4 and 2
    int tc4 = 0, tc2 = 0;
    bit ph4 = 1'b0, ph2 = 1'b0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    assign jp_latch_n = ~jp_latch;

    always #5 clk_in = ~clk_in;

    joypad_responder u_main (
        .clk_in(clk_in), .rst_in(rst_in), .jp_latch_in(jp_latch), .jp_clk_in(jp_clk),
        .buttons_in(buttons), .turbo_a_in(turbo_a), .turbo_b_in(turbo_b),
        .jp_data_out(data_m), .bit_cnt_out(cnt_m), .frame_strobe_out(strb_m)
    );

    joypad_responder #(.TURBO_FRAMES(2)) u_turbo (
        .clk_in(clk_in), .rst_in(rst_in), .jp_latch_in(jp_latch), .jp_clk_in(jp_clk),
        .buttons_in(buttons), .turbo_a_in(turbo_a), .turbo_b_in(turbo_b),
        .jp_data_out(data_t), .bit_cnt_out(cnt_t), .frame_strobe_out(strb_t)
    );

    joypad_responder #(.LATCH_ACTIVE_HIGH(1'b0), .DATA_ACTIVE_LOW(1'b0)) u_pol (
        .clk_in(clk_in), .rst_in(rst_in), .jp_latch_in(jp_latch_n), .jp_clk_in(jp_clk),
        .buttons_in(buttons), .turbo_a_in(turbo_a), .turbo_b_in(turbo_b),
        .jp_data_out(data_p), .bit_cnt_out(cnt_p), .frame_strobe_out(strb_p)
    );

    always @(posedge clk_in) begin
        if (strb_m) nstrb_m <= nstrb_m + 1;
        if (strb_t) nstrb_t <= nstrb_t + 1;
        if (strb_p) nstrb_p <= nstrb_p + 1;
    end

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0:       return 32'(data_m);
            1:       return 32'(cnt_m);
            2:       return 32'(data_t);
            3:       return 32'(cnt_t);
            4:       return 32'(data_p);
            5:       return 32'(cnt_p);
            6:       return 32'(nstrb_m);
            7:       return 32'(nstrb_t);
            8:       return 32'(nstrb_p);
            9:       return 32'(strb_m);
            10:      return 32'(strb_p);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [7:0] eff(input logic [7:0] b, input bit ph);
        logic [7:0] e;
        e    = b;
        e[0] = b[0] & (~turbo_a | ph);
        e[1] = b[1] & (~turbo_b | ph);
        return e;
    endfunction

    // Bit k of the stream: latched button k, then pressed level once exhausted.
    function automatic logic [31:0] exp_bit(input logic [7:0] b, input int k, input bit dal);
        logic pressed;
        pressed = (k < 8) ? b[k] : 1'b1;
        return 32'(pressed ^ dal);
    endfunction

    task automatic push(input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic advance_turbo();
        if (tc4 == 3) begin tc4 = 0; ph4 = ~ph4; end else tc4++;
        if (tc2 == 1) begin tc2 = 0; ph2 = ~ph2; end else tc2++;
    endtask

    task automatic push_reads(input int k, input logic [7:0] e4, input logic [7:0] e2);
        int c;
        c = (k > 8) ? 8 : k;
        push($sformatf("data_main_b%0d", k), 0, exp_bit(e4, k, 1'b1));
        push($sformatf("cnt_main_b%0d", k), 1, 32'(c));
        push($sformatf("data_turbo_b%0d", k), 2, exp_bit(e2, k, 1'b1));
        push($sformatf("cnt_turbo_b%0d", k), 3, 32'(c));
        push($sformatf("data_pol_b%0d", k), 4, exp_bit(e4, k, 1'b0));
        push($sformatf("cnt_pol_b%0d", k), 5, 32'(c));
        push("strobes_main", 6, 32'(frames));
        push("strobes_turbo", 7, 32'(frames));
        push("strobes_pol", 8, 32'(frames));
    endtask

    task automatic jclk_pulse();
        jp_clk = 1'b0;
        cycles(4);
        jp_clk = 1'b1;
        cycles(4);
    endtask

    // One latch pulse then nclk host clocks, checking every bit of the stream.
    task automatic run_frame(input int nclk);
        logic [7:0] e4, e2;
        e4 = eff(buttons, ph4);
        e2 = eff(buttons, ph2);
        jp_latch = 1'b1;
        cycles(5);
        jp_latch = 1'b0;
        cycles(5);
        frames++;
        advance_turbo();
        push_reads(0, e4, e2);
        @(negedge clk_in);
        check_all();
        for (int k = 1; k <= nclk; k++) begin
            jclk_pulse();
            push_reads(k, e4, e2);
            @(negedge clk_in);
            check_all();
        end
    endtask

    initial begin
        rst_in   = 1'b1;
        jp_latch = 1'b0;
        jp_clk   = 1'b1;
        buttons  = 8'h00;
        turbo_a  = 1'b0;
        turbo_b  = 1'b0;

        // Reset state
        cycles(3);
        @(negedge clk_in);
        push("rst_data_main", 0, 32'd1);
        push("rst_cnt_main", 1, 32'd0);
        push("rst_strobe_main", 9, 32'd0);
        push("rst_data_turbo", 2, 32'd1);
        push("rst_data_pol", 4, 32'd0);
        push("rst_strobe_pol", 10, 32'd0);
        check_all();
        rst_in = 1'b0;
        cycles(3);

        // Basic read, A first, active-low
        buttons = 8'b1000_0101;
        run_frame(8);

        // Overrun past eight bits
        buttons = 8'h00;
        run_frame(12);

        // Load priority: clocks ignored while latched, buttons transparent
        buttons  = 8'h01;
        jp_latch = 1'b1;
        cycles(5);
        @(negedge clk_in);
        push("load_data_main", 0, 32'd0);
        push("load_cnt_main", 1, 32'd0);
        push("load_data_pol", 4, 32'd1);
        check_all();
        jclk_pulse();
        jclk_pulse();
        @(negedge clk_in);
        push("load_clk_data_main", 0, 32'd0);
        push("load_clk_cnt_main", 1, 32'd0);
        push("load_clk_cnt_pol", 5, 32'd0);
        check_all();
        buttons = 8'h00;
        cycles(1);
        @(negedge clk_in);
        push("load_update_main", 0, 32'd1);
        push("load_update_pol", 4, 32'd0);
        check_all();
        jp_latch = 1'b0;
        cycles(5);
        frames++;
        advance_turbo();
        @(negedge clk_in);
        push("load_strobes_main", 6, 32'(frames));
        check_all();

        // Asynchronous reset in the middle of a shift
        buttons = 8'h01;
        run_frame(0);
        jp_clk = 1'b0;
        cycles(2);
        #2;
        rst_in = 1'b1;
        #1;
        push("midrst_data_main", 0, 32'd1);
        push("midrst_cnt_main", 1, 32'd0);
        push("midrst_strobe_main", 9, 32'd0);
        push("midrst_data_pol", 4, 32'd0);
        check_all();
        tc4 = 0; tc2 = 0; ph4 = 1'b0; ph2 = 1'b0;
        cycles(2);
        jp_clk = 1'b1;
        cycles(1);
        rst_in = 1'b0;
        cycles(4);

        // Turbo on A: eight frames, first bit follows the turbo phase
        turbo_a = 1'b1;
        buttons = 8'h01;
        for (int f = 0; f < 8; f++) run_frame(1);
        turbo_a = 1'b0;

        // Polarity instance: A only, run past the end of the stream
        buttons = 8'h01;
        run_frame(9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joypad_responder.md
# joypad_responder

Controller-side responder for the NES joypad serial protocol, the other end of the latch/clock/data interface driven by the rp2a03 joypad port. It samples eight board-level button inputs, loads them on latch, and shifts them out one bit per joypad clock edge, exactly as a 4021-based controller does. Auto-fire on A/B and a per-frame strobe are included. It sits between on-board buttons (or a bench) and the jp_latch/jp_clk/jp_data pins, or is looped back internally for controller-less boards.

## Interface
- SYNC_STAGES, 2: synchronizer depth on jp_latch_in and jp_clk_in (min 2).
- LATCH_ACTIVE_HIGH, 1: 1 = latch asserted when jp_latch_in high; 0 = asserted when low.
- DATA_ACTIVE_LOW, 1: 1 = pressed bit driven as 0 on jp_data_out.
- TURBO_FRAMES, 4: latch strobes per turbo phase toggle (≥1).
- clk_in  input  1  system clock (clk_25 domain).
- rst_in  input  1  asynchronous reset, active-high.
- jp_latch_in  input  1  latch/strobe from host, asynchronous.
- jp_clk_in  input  1  serial clock from host, asynchronous, idles high.
- buttons_in  input  8  logical pressed = 1; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- turbo_a_in  input  1  enable auto-fire on A.
- turbo_b_in  input  1  enable auto-fire on B.
- jp_data_out  output  1  serial data to host.
- bit_cnt_out  output  4  bits shifted since last latch, 0..8, saturating.
- frame_strobe_out  output  1  one-cycle pulse on latch deassert.

## Operation
- Synchronizers: jp_latch_in, jp_clk_in each pass SYNC_STAGES flops; latch normalized to latch_s (1 = asserted) per LATCH_ACTIVE_HIGH. Registered previous values latch_q, clk_q for edge detection.
- Effective buttons: eff = buttons_in, except eff[0] = buttons_in[0] & (~turbo_a_in | turbo_phase), eff[1] likewise with turbo_b_in.
- States: LOAD (latch_s = 1) and SHIFT (latch_s = 0); state is latch_s itself, no extra FSM register.
- LOAD: shift_reg <= eff every cycle (transparent, continuous reload); bit_cnt <= 0; clock edges ignored.
- Latch falling edge (latch_q = 1, latch_s = 0): frame_strobe_out = 1 for that cycle; turbo counter increments, wraps at TURBO_FRAMES-1 to 0 and toggles turbo_phase on wrap.
- SHIFT, clk rising edge (clk_q = 0, clk_s = 1): shift_reg <= {1'b1, shift_reg[7:1]}; bit_cnt <= min(bit_cnt+1, 8). After 8 shifts the serial stream reads pressed-level forever (official-controller behaviour).
- jp_data_out = shift_reg[0] ^ DATA_ACTIVE_LOW, driven from a register, glitch-free.
- Simultaneous: latch asserted and clk edge in same cycle -> load wins, no shift, bit_cnt = 0. Clk rise in the same cycle latch_s falls -> shift occurs (SHIFT state already active).
- Counter widths: turbo counter $clog2(TURBO_FRAMES) bits (min 1); bit_cnt 4 bits, never exceeds 8.

## Timing
- Reset values: all sync flops and latch_q/clk_q to deasserted latch, clk high; shift_reg = 0; jp_data_out = DATA_ACTIVE_LOW (released); bit_cnt_out = 0; frame_strobe_out = 0; turbo counter 0; turbo_phase 0.
- Reset mid-frame: immediate return to reset values; first post-reset latch reloads normally.
- Latency: pin edge to jp_data_out change = SYNC_STAGES + 1 clk_in rising edges (3 at default).
- Host requirement: jp_clk_in and jp_latch_in high and low phases each ≥ SYNC_STAGES+1 clk_in periods; shorter pulses may be lost (not an error).
- buttons_in sampled each cycle during LOAD; value in flight on the last LOAD cycle is the one shifted out.

## Test plan
- Reset: assert rst_in mid-shift -> jp_data_out = 1, bit_cnt_out = 0, frame_strobe_out = 0 within same cycle (async).
- Basic read: buttons_in = 8'b1000_0101, latch pulse then 8 clk pulses -> jp_data_out sequence 0,1,0,1,1,1,1,0 (active low, A first), bit_cnt_out 1..8, one frame_strobe_out pulse.
- Overrun: 12 clk pulses after latch, buttons_in = 0 -> bits 1-8 read 1, bits 9-12 read 0; bit_cnt_out holds 8.
- Load priority: clk pulses while latch held high -> jp_data_out stays at bit0 of buttons_in, bit_cnt_out = 0; changing buttons_in[0] during latch updates jp_data_out after 1 cycle.
- Turbo: TURBO_FRAMES = 2, turbo_a_in = 1, A held, 8 frames -> first-bit reads released,released,pressed,pressed,released,released,pressed,pressed.
- Polarity: LATCH_ACTIVE_HIGH = 0, DATA_ACTIVE_LOW = 0, buttons_in = 8'h01 -> low latch loads, first bit reads 1, later bits 0, post-8 reads 1.
